// File: rtl/judge_pkg.sv
// judge_pkg: shared state encoding, default parameters and counter-width helper for judge_seq.
package judge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        RESULT,
        LOCKOUT
    } state_t;

    localparam int DEF_N_DIGITS       = 6;
    localparam int DEF_DIGIT_W        = 4;
    localparam int DEF_MAX_TRIES      = 3;
    localparam int DEF_LOCKOUT_CYCLES = 1000;

    // Bits needed to hold the values 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/judge_lockout_timer.sv
// judge_lockout_timer: down-counter loaded with LOCKOUT_CYCLES-1, expired high at zero.
// Ports: clk, rst (sync, active high), load (reload the count), expired (count is zero).
module judge_lockout_timer
    import judge_pkg::*;
#(
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);

    localparam int W = cnt_w(LOCKOUT_CYCLES);
    localparam logic [W-1:0] INIT = W'(LOCKOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= load ? INIT : (cnt != '0 ? cnt - 1'b1 : cnt);
    end

    assign expired = cnt == '0;

endmodule

// File: rtl/judge_seq.sv
// judge_seq: constant-time N-digit code judge with consecutive-failure lockout.
// Ports: clk, rst (sync, active high); start, entered, stored in;
// busy, done, match, fail, locked, tries_left out (all registered).
// Define JUDGE_ALARM_EN to add the alarm and lockout_count outputs.
module judge_seq
    import judge_pkg::*;
#(
    parameter int N_DIGITS       = DEF_N_DIGITS,
    parameter int DIGIT_W        = DEF_DIGIT_W,
    parameter int MAX_TRIES      = DEF_MAX_TRIES,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [N_DIGITS*DIGIT_W-1:0]       entered,
    input  logic [N_DIGITS*DIGIT_W-1:0]       stored,
    output logic                              busy,
    output logic                              done,
    output logic                              match,
    output logic                              fail,
    output logic                              locked,
    output logic [cnt_w(MAX_TRIES+1)-1:0]     tries_left
`ifdef JUDGE_ALARM_EN
    ,
    output logic                              alarm,
    output logic [7:0]                        lockout_count
`endif
);

    localparam int CW = N_DIGITS * DIGIT_W;
    localparam int IW = cnt_w(N_DIGITS);
    localparam int TW = cnt_w(MAX_TRIES + 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIGITS - 1);
    localparam logic [TW-1:0] TRIES_MAX = TW'(MAX_TRIES);

    state_t        state, state_n;
    logic [CW-1:0] ent_q, sto_q, ent_n, sto_n;
    logic [IW-1:0] idx, idx_n;
    logic [TW-1:0] fail_cnt, fail_cnt_n, tries_n;
    logic          mis, mis_n, match_n, fail_n, diff, tmr_load, expired;

    // Captured codes shift down one digit per compare cycle, so digit idx is always at the bottom.
    assign diff = ent_q[DIGIT_W-1:0] != sto_q[DIGIT_W-1:0];

    judge_lockout_timer #(
        .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (tmr_load),
        .expired(expired)
    );

    always_comb begin
        state_n    = state;
        ent_n      = ent_q;
        sto_n      = sto_q;
        idx_n      = idx;
        mis_n      = mis;
        fail_cnt_n = fail_cnt;
        tries_n    = tries_left;
        match_n    = match;
        fail_n     = 1'b0;
        tmr_load   = 1'b0;
        case (state)
            IDLE: if (start) begin
                state_n = COMPARE;
                ent_n   = entered;
                sto_n   = stored;
                idx_n   = '0;
                mis_n   = 1'b0;
                match_n = 1'b0;
            end
            COMPARE: begin
                mis_n = mis | diff;
                ent_n = ent_q >> DIGIT_W;
                sto_n = sto_q >> DIGIT_W;
                idx_n = idx + 1'b1;
                // Verdict and attempt bookkeeping land together with done.
                if (idx == IDX_LAST) begin
                    state_n    = RESULT;
                    match_n    = ~mis_n;
                    fail_n     = mis_n;
                    fail_cnt_n = mis_n ? (fail_cnt == TRIES_MAX ? fail_cnt : fail_cnt + 1'b1) : '0;
                    tries_n    = TRIES_MAX - fail_cnt_n;
                end
            end
            RESULT: if (fail && fail_cnt == TRIES_MAX) begin
                state_n  = LOCKOUT;
                tmr_load = 1'b1;
                match_n  = 1'b0;
            end else begin
                state_n = IDLE;
            end
            LOCKOUT: if (expired) begin
                state_n    = IDLE;
                fail_cnt_n = '0;
                tries_n    = TRIES_MAX;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ent_q      <= '0;
            sto_q      <= '0;
            idx        <= '0;
            mis        <= 1'b0;
            fail_cnt   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            match      <= 1'b0;
            fail       <= 1'b0;
            locked     <= 1'b0;
            tries_left <= TRIES_MAX;
        end else begin
            state      <= state_n;
            ent_q      <= ent_n;
            sto_q      <= sto_n;
            idx        <= idx_n;
            mis        <= mis_n;
            fail_cnt   <= fail_cnt_n;
            busy       <= state_n == COMPARE || state_n == RESULT;
            done       <= state_n == RESULT;
            match      <= match_n;
            fail       <= fail_n;
            locked     <= state_n == LOCKOUT;
            tries_left <= tries_n;
        end
    end

`ifdef JUDGE_ALARM_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            alarm         <= 1'b0;
            lockout_count <= 8'd0;
        end else begin
            alarm <= state_n == LOCKOUT;
            if (tmr_load && lockout_count != 8'hFF)
                lockout_count <= lockout_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_judge_seq.sv
// tb_judge_seq: random and directed scoreboard bench for judge_seq (default and minimal configs).
module tb_judge_seq;

    localparam int N  = 6;
    localparam int DW = 4;
    localparam int MT = 3;
    localparam int LC = 1000;
    localparam int W  = N * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, busy, done, match, fail, locked;
    logic [W-1:0] entered, stored;
    logic [1:0]   tries_left;
    logic         rst2, start2, busy2, done2, match2, fail2, locked2;
    logic [7:0]   ent2, sto2;
    logic [0:0]   tries2;
`ifdef JUDGE_ALARM_EN
    logic         alarm, alarm2;
    logic [7:0]   lockout_count, lockout_count2;
`endif

    judge_seq #(.N_DIGITS(N), .DIGIT_W(DW), .MAX_TRIES(MT), .LOCKOUT_CYCLES(LC)) dut (
        .clk(clk), .rst(rst), .start(start), .entered(entered), .stored(stored),
        .busy(busy), .done(done), .match(match), .fail(fail), .locked(locked),
        .tries_left(tries_left)
`ifdef JUDGE_ALARM_EN
        , .alarm(alarm), .lockout_count(lockout_count)
`endif
    );

    judge_seq #(.N_DIGITS(1), .DIGIT_W(8), .MAX_TRIES(1), .LOCKOUT_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst2), .start(start2), .entered(ent2), .stored(sto2),
        .busy(busy2), .done(done2), .match(match2), .fail(fail2), .locked(locked2),
        .tries_left(tries2)
`ifdef JUDGE_ALARM_EN
        , .alarm(alarm2), .lockout_count(lockout_count2)
`endif
    );

    typedef struct {
        int   d;
        logic m;
        int   tries;
    } exp_t;

    exp_t sbq[$];
    exp_t cur;
    int   cyc = 0;
    int   tests = 0;
    int   errs = 0;
    logic mon_on = 1'b0;
    int   ready = 0, fails = 0;
    int   busy_lo = 1, busy_hi = 0, lock_lo = 1, lock_hi = 0;
    int   rst_cyc = -10, last_d = -10, last_tries = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    function automatic logic [W-1:0] rnd();
        return W'($urandom);
    endfunction

    function automatic logic [W-1:0] flip(input logic [W-1:0] v);
        return v ^ (W'($urandom_range(1, 15)) << (DW * $urandom_range(0, N - 1)));
    endfunction

    // Transaction-level reference: a start in an idle cycle c yields a verdict at c+N+1;
    // the MT-th consecutive failure locks the block for LC cycles right after the verdict.
    task automatic step(input logic r, input logic s, input logic [W-1:0] e, input logic [W-1:0] st);
        int   d, tr;
        logic m;
        rst = r;
        start = s;
        entered = e;
        stored = st;
        if (r) begin
            while (sbq.size() > 0 && sbq[$].d > cyc) void'(sbq.pop_back());
            if (busy_hi > cyc) busy_hi = cyc;
            if (lock_hi > cyc) lock_hi = cyc;
            fails = 0;
            ready = cyc + 1;
            rst_cyc = cyc;
        end else if (s && cyc >= ready) begin
            d = cyc + N + 1;
            m = e == st;
            busy_lo = cyc + 1;
            busy_hi = d;
            fails = m ? 0 : fails + 1;
            if (fails == MT) begin
                lock_lo = d + 1;
                lock_hi = d + LC;
                ready = d + LC + 1;
                fails = 0;
                tr = 0;
            end else begin
                ready = d + 1;
                tr = MT - fails;
            end
            sbq.push_back('{d, m, tr});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        while (cyc < ready) step(1'b0, 1'($urandom % 2), rnd(), rnd());
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            chk("busy", 32'(busy), 32'(cyc >= busy_lo && cyc <= busy_hi));
            chk("locked", 32'(locked), 32'(cyc >= lock_lo && cyc <= lock_hi));
`ifdef JUDGE_ALARM_EN
            chk("alarm", 32'(alarm), 32'(cyc >= lock_lo && cyc <= lock_hi));
`endif
            if (cyc == rst_cyc + 1) begin
                chk("rst_tries", 32'(tries_left), MT);
                chk("rst_done", 32'(done), 0);
            end
            if (lock_lo <= lock_hi && cyc == lock_hi + 1) chk("unlock_tries", 32'(tries_left), MT);
            if (cyc == last_d + 1 && rst_cyc != last_d) chk("tries_after", 32'(tries_left), last_tries);
            if (!done) chk("fail_no_done", 32'(fail), 0);
            if (done) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_done", 32'(done), 0);
                end else begin
                    cur = sbq.pop_front();
                    chk("done_cycle", cyc, cur.d);
                    chk("match", 32'(match), 32'(cur.m));
                    chk("fail", 32'(fail), 32'(!cur.m));
                    last_d = cyc;
                    last_tries = cur.tries;
                end
            end else if (sbq.size() > 0 && sbq[0].d <= cyc) begin
                chk("missing_done", 32'(done), 1);
                void'(sbq.pop_front());
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] v, st, e;
        rst = 1'b1; start = 1'b0; entered = '0; stored = '0;
        rst2 = 1'b1; start2 = 1'b0; ent2 = '0; sto2 = '0;
        // Minimal configuration: one 8-bit digit, first failure locks for one cycle.
        repeat (3) @(posedge clk);
        #1 rst2 = 1'b0;
        @(negedge clk);
        chk("p_rst_tries", 32'(tries2), 1);
        chk("p_rst_busy", 32'(busy2), 0);
        chk("p_rst_locked", 32'(locked2), 0);
        chk("p_rst_done", 32'(done2), 0);
        @(posedge clk);
        #1 ent2 = 8'h5A; sto2 = 8'hA5; start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0; ent2 = 8'h33; sto2 = 8'h33;
        @(negedge clk);
        chk("p_busy", 32'(busy2), 1);
        chk("p_done_early", 32'(done2), 0);
        @(negedge clk);
        chk("p_done", 32'(done2), 1);
        chk("p_fail", 32'(fail2), 1);
        chk("p_match", 32'(match2), 0);
        @(posedge clk);
        #1 start2 = 1'b1; ent2 = 8'h77; sto2 = 8'h77;
        @(negedge clk);
        chk("p_locked", 32'(locked2), 1);
        chk("p_lock_tries", 32'(tries2), 0);
        chk("p_lock_done", 32'(done2), 0);
`ifdef JUDGE_ALARM_EN
        chk("p_alarm", 32'(alarm2), 1);
        chk("p_lockout_count", 32'(lockout_count2), 1);
`endif
        @(negedge clk);
        chk("p_unlocked", 32'(locked2), 0);
        chk("p_unlock_tries", 32'(tries2), 1);
`ifdef JUDGE_ALARM_EN
        chk("p_alarm_off", 32'(alarm2), 0);
`endif
        @(posedge clk);
        #1 start2 = 1'b0;
        @(negedge clk);
        chk("p_not_queued", 32'(done2), 0);
        chk("p_busy2", 32'(busy2), 1);
        @(negedge clk);
        chk("p_done2", 32'(done2), 1);
        chk("p_match2", 32'(match2), 1);
        chk("p_fail2", 32'(fail2), 0);
        @(negedge clk);
        chk("p_match_held", 32'(match2), 1);
        chk("p_tries_held", 32'(tries2), 1);
`ifdef JUDGE_ALARM_EN
        chk("p_lockout_count_held", 32'(lockout_count2), 1);
`endif
        // Default configuration.
        @(posedge clk);
        #1;
        repeat (2) step(1'b1, 1'b0, '0, '0);
        mon_on = 1'b1;
        step(1'b0, 1'b1, 24'h123456, 24'h123456); wait_ready();
        step(1'b0, 1'b1, 24'h123457, 24'h123456); wait_ready();
        step(1'b0, 1'b1, 24'h023456, 24'h123456); wait_ready();
        step(1'b0, 1'b1, 24'h999999, 24'h999999); wait_ready();
        repeat (2) begin step(1'b0, 1'b1, 24'h111111, 24'h111112); wait_ready(); end
        step(1'b0, 1'b1, 24'h000000, 24'h000000); wait_ready();
        repeat (3) begin step(1'b0, 1'b1, 24'h654321, 24'h123456); wait_ready(); end
        repeat (3) step(1'b0, 1'b0, rnd(), rnd());
        step(1'b0, 1'b1, 24'h100000, 24'h000000);
        repeat (2) step(1'b0, 1'b0, rnd(), rnd());
        step(1'b1, 1'b0, rnd(), rnd());
        repeat (12) step(1'b0, 1'b0, rnd(), rnd());
        repeat (2) begin step(1'b0, 1'b1, 24'h000001, 24'h000000); wait_ready(); end
        step(1'b0, 1'b1, 24'h000001, 24'h000000);
        repeat (100) step(1'b0, 1'b0, rnd(), rnd());
        step(1'b1, 1'b0, rnd(), rnd());
        repeat (5) step(1'b0, 1'b0, rnd(), rnd());
        repeat (40) begin v = rnd(); step(1'b0, 1'b1, v, v); end
        wait_ready();
        repeat (3000) begin
            st = rnd();
            e = ($urandom % 4 != 0) ? st : flip(st);
            step(1'($urandom_range(0, 399) == 0), 1'($urandom % 3 == 0), e, st);
        end
        wait_ready();
        repeat (5) step(1'b0, 1'b0, rnd(), rnd());
        chk("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end

endmodule

// File: doc/judge_seq.md
Name: judge_seq

Overview:
- Parametrised sequential successor to the six-digit combinational password judge.
- Compares an N-digit entered code against a stored code, one digit per clock. Reports match/fail with a done pulse.
- Counts consecutive failures and enforces a timed lockout after MAX_TRIES.
- Sits between the keypad entry register bank and the lock actuator / display controller.

Parameters:
- N_DIGITS, 6, number of code digits (1..16)
- DIGIT_W, 4, bits per digit (BCD default)
- MAX_TRIES, 3, consecutive failures that trigger lockout (1..15)
- LOCKOUT_CYCLES, 1000, clock cycles the block stays locked (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle request to judge; sampled only in IDLE
- entered  in  N_DIGITS*DIGIT_W  entered code; digit i at [i*DIGIT_W +: DIGIT_W]
- stored  in  N_DIGITS*DIGIT_W  reference code, same packing
- busy  out  1  high in COMPARE and RESULT
- done  out  1  one-cycle pulse when the verdict is valid
- match  out  1  verdict, valid with done; held until next start
- fail  out  1  one-cycle pulse with done when codes differ
- locked  out  1  high throughout LOCKOUT
- tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts before lockout

Behaviour:
- Clock and reset: single clock clk; synchronous active-high reset rst.
- Reset values: state=IDLE, busy=0, done=0, match=0, fail=0, locked=0, tries_left=MAX_TRIES, fail count=0, timers=0.
- All outputs are registered.
- FSM states: IDLE, COMPARE, RESULT, LOCKOUT.
- IDLE:
  - On start=1, capture entered and stored into internal registers, clear the mismatch accumulator, set digit index=0, go to COMPARE.
  - Inputs may change after the capture cycle.
- COMPARE:
  - Each cycle, mismatch |= (ent[idx] != sto[idx]); idx++.
  - After the digit N_DIGITS-1 cycle, go to RESULT.
  - All N_DIGITS digits are always compared (constant time, no early exit).
- RESULT, for one cycle:
  - done=1; match=~mismatch; fail=mismatch.
  - On match: fail count := 0, tries_left=MAX_TRIES, go to IDLE.
  - On fail: fail count++ and tries_left--.
    - If the count reaches MAX_TRIES: tries_left=0, go to LOCKOUT, locked=1, load timer with LOCKOUT_CYCLES-1.
    - Otherwise go to IDLE.
- LOCKOUT:
  - Timer decrements each cycle.
  - In the cycle the timer is 0: go to IDLE, locked=0, fail count=0, tries_left=MAX_TRIES.
  - locked is high for exactly LOCKOUT_CYCLES cycles.
- Latency: start sampled in cycle T; done asserted in cycle T+N_DIGITS+1.
- start outside IDLE (COMPARE, RESULT, LOCKOUT) is ignored and not queued.
- start held high continuously: a new judgement begins in each IDLE cycle, so back-to-back operation is every N_DIGITS+2 cycles.
- match is cleared to 0 when a new start is accepted, and during LOCKOUT entry.
- Reset mid-operation (any state): immediate return to reset values. The fail count is lost (lockout is cancelled by rst).
- MAX_TRIES=1: the first failure locks.
- LOCKOUT_CYCLES=1: locked for one cycle.
- The fail counter saturates; it never wraps.

Optional Feature:
- Macro: JUDGE_ALARM_EN
- With the macro defined:
  - Extra output port alarm (out, 1).
  - Asserted on the cycle LOCKOUT is entered and held until lockout expires or rst.
  - An additional 8-bit saturating lockout_count output counts lockout events since reset, saturating at 255.
- Without the macro: no alarm or lockout_count ports, no associated logic; all other behaviour is identical.

Decomposition:
- Package judge_pkg holds:
  - state enum (IDLE, COMPARE, RESULT, LOCKOUT), 2 bits;
  - default parameter constants;
  - helper function for counter widths ($clog2-based) for the digit index, tries and the lockout timer.
- One sub-module: judge_lockout_timer.
  - Ports: clk, rst, load, expired.
  - Parameter LOCKOUT_CYCLES.
  - Down-counter asserting expired on terminal count.
- Digit comparison stays inline in judge_seq.

Test Plan:
- Match: default params, stored=entered=0x123456, start pulse at T → done=1 and match=1 at T+7, fail=0, tries_left stays 3, busy high for T+1..T+7.
- Single mismatch in last digit: stored=0x123456, entered=0x123457 → done at T+7 (no early exit), fail=1, match=0, tries_left=2.
- Lockout: three consecutive mismatches → third RESULT sets locked=1 next cycle. locked stays high exactly 1000 cycles, tries_left=0, and starts during lockout produce no done. After expiry tries_left=3.
- Recovery: two fails, then a match → tries_left returns to 3. Two further fails do not lock (locked stays 0).
- Reset mid-compare and mid-lockout: rst at T+3 → next cycle busy=0, done=0 and no done pulse follows. rst during lockout → locked=0, tries_left=3 next cycle.
- Parameter sweep: N_DIGITS=1, DIGIT_W=8, MAX_TRIES=1, LOCKOUT_CYCLES=1 → done at T+2, the first fail locks for one cycle. With JUDGE_ALARM_EN, alarm high with locked and lockout_count increments to 1.
